mem_access_stage: RTL and testbench

- MEM-stage data-memory engine of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the MEM/WB register.
- Takes the EX/MEM load/store request and runs a request/acknowledge transaction on a variable-latency data bus.
- Returns the sign/zero-extended load result as m_memRd.
- Asserts m_stall to freeze PC/IF/ID/EX/MEM and bubble MEM/WB until the access completes.

---
 rtl/mem_stage_pkg.sv | 53 +++++
 rtl/mem_lane_align.sv | 26 ++
 rtl/mem_access_stage.sv | 134 +++++++++++++
 tb/tb_mem_access_stage.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM-stage data-memory engine:
// FSM states, access-size codes, byte-enable and load-lane functions.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEFAULT_MAX_WAIT = 16;

  // Natural alignment: the reserved size code behaves as a word.
  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] gen_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] rdata, input logic [1:0] size,
                                               input logic sign, input logic [1:0] off);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      SZ_BYTE: return {{24{sign & lane[7]}}, lane[7:0]};
      SZ_HALF: return {{16{sign & lane[15]}}, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  always_comb begin
    be        = gen_be(size, offset);
    rdata_ext = lane_extract(rdata, size, sign, offset);
    case (size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store engine: req/ack bus transaction with stall and timeout.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_valid,
  input  logic              m_mem_rd,
  input  logic              m_mem_wr,
  input  logic [1:0]        m_size,
  input  logic              m_sign,
  input  logic [31:0]       m_addr,
  input  logic [31:0]       m_wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  output logic [31:0]       m_memRd,
  output logic              m_stall,
  output logic              m_misalign,
  output logic              bus_timeout
);

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  lat_size;
  logic [1:0]  lat_off;
  logic        lat_sign;
  logic        lat_rd;

  logic        access;
  logic        misal;
  logic        start;
  logic [1:0]  eff_off;
  logic [1:0]  la_size;
  logic [1:0]  la_off;
  logic [3:0]  la_be;
  logic [31:0] la_wdata;
  logic [31:0] la_rdata;

  always_comb begin
    access  = m_valid & (m_mem_rd | m_mem_wr);
    eff_off = align_offset(m_size, m_addr[1:0]);
`ifdef MEM_MISALIGN_TRAP_EN
    misal   = access & is_misaligned(m_size, m_addr[1:0]);
`else
    misal   = 1'b0;
`endif
    start   = (state == ST_IDLE) & access & ~misal;
    m_stall = start | (state == ST_REQ);
    // One lane unit serves both directions: request fields in IDLE, load data in REQ.
    la_size = (state == ST_IDLE) ? m_size  : lat_size;
    la_off  = (state == ST_IDLE) ? eff_off : lat_off;
  end

  mem_lane_align u_lane (
    .size      (la_size),
    .sign      (lat_sign),
    .offset    (la_off),
    .wdata     (m_wdata),
    .rdata     (bus_rdata),
    .be        (la_be),
    .wdata_rep (la_wdata),
    .rdata_ext (la_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      lat_size    <= '0;
      lat_off     <= '0;
      lat_sign    <= 1'b0;
      lat_rd      <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= '0;
      bus_wdata   <= '0;
      m_memRd     <= '0;
      m_misalign  <= 1'b0;
      bus_timeout <= 1'b0;
    end else begin
      m_misalign <= misal & (state == ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_REQ;
            bus_req   <= 1'b1;
            bus_we    <= m_mem_wr;
            bus_addr  <= {m_addr[ADDR_W-1:2], 2'b00};
            bus_be    <= la_be;
            bus_wdata <= la_wdata;
            lat_size  <= m_size;
            lat_sign  <= m_sign;
            lat_off   <= eff_off;
            lat_rd    <= m_mem_rd;
            wait_cnt  <= '0;
          end
        end
        ST_REQ: begin
          // Ack takes priority over an expiring wait counter.
          if (bus_ack) begin
            bus_req <= 1'b0;
            m_memRd <= lat_rd ? la_rdata : 32'd0;
            state   <= ST_DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            bus_req     <= 1'b0;
            bus_timeout <= 1'b1;
            m_memRd     <= '0;
            state       <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          m_memRd <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage (default build, trap disabled).
module tb_mem_access_stage;
  localparam int MW = 4;

  logic        clk;
  logic        reset;
  logic        m_valid, m_mem_rd, m_mem_wr, m_sign;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata, m_memRd;
  logic [3:0]  bus_be;
  logic        m_stall, m_misalign, bus_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(.MAX_WAIT(MW), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_mem_rd(m_mem_rd), .m_mem_wr(m_mem_wr),
    .m_size(m_size), .m_sign(m_sign), .m_addr(m_addr), .m_wdata(m_wdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .m_memRd(m_memRd),
    .m_stall(m_stall), .m_misalign(m_misalign), .bus_timeout(bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr, wdata, rdata;
    int          k;          // REQ cycles until ack; 0 = never ack
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_rd;
    logic        e_to;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chk(name, 32'(act), 32'(exp));
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] size,
                              input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int k, input logic [31:0] e_addr,
                              input logic [3:0] e_be, input logic [31:0] e_wdata,
                              input logic [31:0] e_rd, input logic e_to);
    vec_t v;
    v.rd = rd; v.wr = wr; v.size = size; v.sign = sign; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.k = k; v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata;
    v.e_rd = e_rd; v.e_to = e_to;
    return v;
  endfunction

  // Reference: naturally-aligned access of nbytes; lanes computed arithmetically.
  function automatic vec_t model(input logic rd, input logic [1:0] size, input logic sign,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] rdata, input int k, input logic to);
    vec_t v;
    int nbytes, off;
    longint mask, val;
    logic [31:0] rep;
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    off = off - (off % nbytes);
    v = mk(rd, !rd, size, sign, addr, wdata, rdata, k, addr - (addr % 4), '0, '0, '0, to);
    v.e_be = 4'(((1 << nbytes) - 1) << off);
    rep = '0;
    for (int b = 0; b < 4; b++) rep[b*8 +: 8] = wdata[(b % nbytes)*8 +: 8];
    v.e_wdata = rep;
    mask = (64'd1 << (8*nbytes)) - 1;
    val = (longint'(rdata) >> (8*off)) & mask;
    if (sign && val[8*nbytes-1]) val = val | ~mask;
    v.e_rd = rd ? val[31:0] : 32'd0;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int stall, reqc, exp_req;
    bit done;
    stall = 0; reqc = 0; done = 0;
    @(posedge clk); #1;
    m_valid = 1'b1; m_mem_rd = v.rd; m_mem_wr = v.wr; m_size = v.size; m_sign = v.sign;
    m_addr = v.addr; m_wdata = v.wdata; bus_rdata = v.rdata;
    if (!v.rd && !v.wr) begin
      @(negedge clk);
      chk1({tag, ".nomem_stall"}, m_stall, 1'b0);
      chk1({tag, ".nomem_req"}, bus_req, 1'b0);
      chk({tag, ".nomem_memrd"}, m_memRd, 32'd0);
      m_valid = 1'b0;
      return;
    end
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (bus_req) begin
        reqc++;
        chk({tag, ".addr"}, bus_addr, v.e_addr);
        chk({tag, ".be"}, 32'(bus_be), 32'(v.e_be));
        chk1({tag, ".we"}, bus_we, v.wr);
        if (v.wr) chk({tag, ".wdata"}, bus_wdata, v.e_wdata);
        bus_ack = (v.k != 0 && reqc == v.k);
      end else if (!m_stall && cyc > 0) begin
        done = 1;
        chk({tag, ".memrd"}, m_memRd, v.e_rd);
        chk1({tag, ".timeout"}, bus_timeout, v.e_to);
        chk1({tag, ".misalign"}, m_misalign, 1'b0);
      end
      if (m_stall) stall++;
      if (!done) begin
        @(posedge clk); #1;
        bus_ack = 1'b0;
      end
    end
    m_valid = 1'b0; m_mem_rd = 1'b0; m_mem_wr = 1'b0;
    chk1({tag, ".completed"}, done, 1'b1);
    exp_req = (v.k == 0) ? MW : v.k;
    chk({tag, ".req_cycles"}, 32'(reqc), 32'(exp_req));
    chk({tag, ".stall_cycles"}, 32'(stall), 32'(exp_req + 1));
  endtask

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; m_valid = 1'b0; m_mem_rd = 1'b0; m_mem_wr = 1'b0; m_size = 2'd0;
    m_sign = 1'b0; m_addr = '0; m_wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk1("rst.req", bus_req, 1'b0);
    chk("rst.addr", bus_addr, 32'd0);
    chk("rst.be", 32'(bus_be), 32'd0);
    chk("rst.wdata", bus_wdata, 32'd0);
    chk("rst.memrd", m_memRd, 32'd0);
    chk1("rst.timeout", bus_timeout, 1'b0);
    chk1("rst.stall", m_stall, 1'b0);
    @(negedge clk); reset = 1'b1;

    //          rd wr size sign addr          wdata         rdata         k  e_addr        e_be     e_wdata       e_rd          to
    vecs.push_back(mk(1, 0, 2'd0, 1, 32'h0000_1003, 32'h0,        32'h80FF_0011, 1, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80, 0));
    vecs.push_back(mk(0, 1, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        3, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0,        0));
    vecs.push_back(mk(0, 0, 2'd2, 0, 32'h0000_0100, 32'h0,        32'h0,        0, 32'h0,         4'b0000, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h0000_0006, 32'h0,        32'hDEAD_BEEF, 2, 32'h0000_0004, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0));
    vecs.push_back(mk(1, 0, 2'd2, 0, 32'h0000_1000, 32'h0,        32'h1234_5678, 4, 32'h0000_1000, 4'b1111, 32'h0,        32'h1234_5678, 0));
    vecs.push_back(mk(1, 0, 2'd0, 0, 32'h0000_2001, 32'h0,        32'h0000_A500, 1, 32'h0000_2000, 4'b0010, 32'h0,        32'h0000_00A5, 0));
    vecs.push_back(mk(1, 0, 2'd1, 1, 32'h0000_3002, 32'h0,        32'h8001_7FFF, 2, 32'h0000_3000, 4'b1100, 32'h0,        32'hFFFF_8001, 0));
    vecs.push_back(mk(0, 1, 2'd2, 0, 32'h0000_0040, 32'hCAFE_F00D, 32'h0,        1, 32'h0000_0040, 4'b1111, 32'hCAFE_F00D, 32'h0,        0));
    vecs.push_back(mk(0, 1, 2'd0, 0, 32'h0000_0041, 32'h0000_00A7, 32'h0,        1, 32'h0000_0040, 4'b0010, 32'hA7A7_A7A7, 32'h0,        0));
    vecs.push_back(mk(1, 0, 2'd3, 1, 32'h0000_0008, 32'h0,        32'h0BAD_F00D, 1, 32'h0000_0008, 4'b1111, 32'h0,        32'h0BAD_F00D, 0));
    vecs.push_back(mk(0, 0, 2'd0, 0, 32'h0000_0000, 32'h0,        32'h0,        0, 32'h0,         4'b0000, 32'h0,        32'h0,        0));

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      logic        rd;
      logic [1:0]  sz;
      rd = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      run_vec(model(rd, sz, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    int'($urandom_range(1, MW)), 1'b0), $sformatf("rnd%0d", i));
    end

    // Unacknowledged lhu times out; the flag stays set for later accesses.
    run_vec(mk(1, 0, 2'd1, 0, 32'h0, 32'h0, 32'hFFFF_FFFF, 0, 32'h0, 4'b0011, 32'h0, 32'h0, 1), "timeout");
    run_vec(mk(1, 0, 2'd2, 0, 32'h0000_0010, 32'h0, 32'h5555_AAAA, 1, 32'h0000_0010, 4'b1111, 32'h0, 32'h5555_AAAA, 1), "sticky");

    // Reset asserted on the second REQ cycle of a lw.
    @(posedge clk); #1;
    m_valid = 1'b1; m_mem_rd = 1'b1; m_mem_wr = 1'b0; m_size = 2'd2; m_addr = 32'h0000_1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk1("midrst.req_before", bus_req, 1'b1);
    reset = 1'b0; m_valid = 1'b0; m_mem_rd = 1'b0;
    #1;
    chk1("midrst.req", bus_req, 1'b0);
    chk1("midrst.we", bus_we, 1'b0);
    chk("midrst.addr", bus_addr, 32'd0);
    chk("midrst.be", 32'(bus_be), 32'd0);
    chk("midrst.memrd", m_memRd, 32'd0);
    chk1("midrst.timeout", bus_timeout, 1'b0);
    chk1("midrst.stall", m_stall, 1'b0);
    @(negedge clk); reset = 1'b1;
    run_vec(mk(1, 0, 2'd2, 0, 32'h0000_1000, 32'h0, 32'h0F0F_1234, 2, 32'h0000_1000, 4'b1111, 32'h0, 32'h0F0F_1234, 0), "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
